exec_mul_seq: RTL and testbench

//  Multi-cycle unsigned shift-add multiplier sequencer. It borrows the execute-stage
//  ALU adder to form each partial sum, so no dedicated adder is needed. It stalls the

---
 rtl/exec_mul_seq.sv | 112 +++++++++++
 tb/tb_exec_mul_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/exec_mul_seq.sv
// Sequential unsigned shift-add multiplier that borrows the execute-stage ALU adder
// for each partial sum; stalls the pipeline and owns the ALU inputs while running.
module exec_mul_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [WIDTH-1:0] alu_rslt,
    input  logic             alu_cout,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;

    // alu_own, busy and done are registered alongside the state so they
    // come straight off flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc_hi  <= '0;
            mplier  <= '0;
            mcand   <= '0;
            cnt     <= '0;
            alu_own <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // start beats abort here; abort alone is a no-op
                    if (start) begin
                        mcand   <= opA;
                        mplier  <= opB;
                        acc_hi  <= '0;
                        cnt     <= '0;
                        state   <= RUN;
                        alu_own <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        alu_own <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        // The ALU sum (and its carry) is only meaningful when the
                        // current multiplier bit adds the multiplicand in.
                        if (mplier[0]) begin
                            acc_hi <= {alu_cout, alu_rslt[WIDTH-1:1]};
                            mplier <= {alu_rslt[0], mplier[WIDTH-1:1]};
                        end else begin
                            acc_hi <= {1'b0, acc_hi[WIDTH-1:1]};
                            mplier <= {acc_hi[0], mplier[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state   <= DONE;
                            alu_own <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    alu_own <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Operands are forced to zero when the pipeline owns the ALU so the mux
    // sees a clean idle value.
    assign alu_a   = alu_own ? acc_hi : '0;
    assign alu_b   = alu_own ? mcand  : '0;
    assign alu_cin = 1'b0;

    // Stall in the accept cycle keeps the MUL parked in execute.
    assign stall   = alu_own | (~busy & start);

    assign prod_hi = acc_hi;
    assign prod_lo = mplier;

endmodule

// File: tb/tb_exec_mul_seq.sv
// Directed bench for exec_mul_seq: stimulus pushes expected products into a
// scoreboard queue, a monitor pops and compares on every done pulse.
module tb_exec_mul_seq;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] opA, opB, alu_rslt, alu_a, alu_b, prod_hi, prod_lo;
    logic        alu_cout, alu_own, alu_cin, stall, busy, done;

    logic [31:0] sb[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    bit          mon_en = 1'b0;

    exec_mul_seq #(.WIDTH(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .opA(opA), .opB(opB), .alu_rslt(alu_rslt), .alu_cout(alu_cout),
        .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .stall(stall), .busy(busy), .done(done),
        .prod_hi(prod_hi), .prod_lo(prod_lo)
    );

    // Execute-stage ALU stand-in
    assign {alu_cout, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && done === 1'b1) begin
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_done: got product %h expected no done pulse",
                             {prod_hi, prod_lo});
                end else begin
                    check("product", {prod_hi, prod_lo}, sb.pop_front());
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        @(negedge clk);
        check({tag, "_busy"},    {31'd0, busy},    32'd0);
        check({tag, "_stall"},   {31'd0, stall},   32'd0);
        check({tag, "_done"},    {31'd0, done},    32'd0);
        check({tag, "_own"},     {31'd0, alu_own}, 32'd0);
        check({tag, "_alu_ab"},  {alu_a, alu_b},   32'd0);
        check({tag, "_cin"},     {31'd0, alu_cin}, 32'd0);
        check({tag, "_product"}, {prod_hi, prod_lo}, 32'd0);
    endtask

    // Full multiply from start in cycle 0; optional extra start at restart_at
    // (must be ignored) and optional abort alongside the accepting start.
    task automatic mul_run(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp, input int restart_at,
                           input bit abort_with_start);
        int stall_n = 0;
        int own_n   = 0;
        int done_at = -1;
        sb.push_back(exp);
        start = 1'b1; opA = a; opB = b; abort = abort_with_start;
        for (int c = 0; c <= 20; c++) begin
            if (c == 1) begin
                start = 1'b0; abort = 1'b0; opA = '0; opB = '0;
            end
            if (restart_at >= 0 && c == restart_at) begin
                start = 1'b1; opA = 16'h0007; opB = 16'h0009;
            end
            if (restart_at >= 0 && c == restart_at + 1) start = 1'b0;
            @(negedge clk);
            if (stall)   stall_n++;
            if (alu_own) own_n++;
            if (done && done_at < 0) done_at = c;
            next_cycle();
        end
        check("done_cycle",   done_at, 17);
        check("stall_cycles", stall_n, 17);
        check("own_cycles",   own_n,   16);
        check("product_hold", {prod_hi, prod_lo}, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; opA = '0; opB = '0;
        repeat (3) next_cycle();
        rst = 1'b0;
        mon_en = 1'b1;
        chk_zero("reset");
        next_cycle();

        mul_run(16'h0003, 16'h0005, 32'h0000_000F, -1, 1'b0);
        mul_run(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, -1, 1'b0);
        mul_run(16'h1234, 16'h0000, 32'h0000_0000, -1, 1'b0);
        mul_run(16'h0102, 16'h0304, 32'h0003_0A08,  5, 1'b0);

        // abort mid-run: no done, back to idle the next cycle
        start = 1'b1; opA = 16'h00AB; opB = 16'h00CD;
        for (int c = 0; c <= 12; c++) begin
            if (c == 1) start = 1'b0;
            if (c == 8) abort = 1'b1;
            if (c == 9) abort = 1'b0;
            @(negedge clk);
            if (c == 7) check("busy_before_abort", {31'd0, busy}, 32'd1);
            if (c == 9) begin
                check("abort_busy",  {31'd0, busy},    32'd0);
                check("abort_own",   {31'd0, alu_own}, 32'd0);
                check("abort_stall", {31'd0, stall},   32'd0);
            end
            next_cycle();
        end
        // abort alone in IDLE does nothing
        abort = 1'b1;
        @(negedge clk);
        check("idle_abort_busy", {31'd0, busy}, 32'd0);
        next_cycle();
        abort = 1'b0;
        // start together with abort in IDLE: start wins
        mul_run(16'h0007, 16'h0006, 32'h0000_002A, -1, 1'b1);

        // synchronous reset mid-run
        start = 1'b1; opA = 16'h1111; opB = 16'h2222;
        for (int c = 0; c <= 10; c++) begin
            if (c == 1)  start = 1'b0;
            if (c == 10) rst = 1'b1;
            if (c < 10) next_cycle();
        end
        next_cycle();
        rst = 1'b0;
        chk_zero("midrun_rst");
        next_cycle();
        mul_run(16'h0002, 16'h0002, 32'h0000_0004, -1, 1'b0);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
